// File: rtl/img_filter_pkg.sv
// Shared types, constants and arithmetic helpers for the 3x3 image filter.
package img_filter_pkg;

  localparam int unsigned PIX_W     = 8;
  localparam int unsigned BOX_MUL   = 57;
  localparam int unsigned BOX_SHIFT = 9;
  localparam int unsigned SUM_W     = 12;          // nine 8-bit pixels
  localparam int unsigned PROD_W    = SUM_W + 6;   // sum * 57
  localparam int unsigned KW        = 12;          // signed kernel width, covers -1020..2040

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_BOX   = 2'd1,
    MODE_SHARP = 2'd2,
    MODE_SOBEL = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  // Zero-extend a pixel into the signed kernel domain.
  function automatic logic signed [KW-1:0] sx(input logic [PIX_W-1:0] p);
    return $signed({{(KW-PIX_W){1'b0}}, p});
  endfunction

  // Saturate a signed kernel result to 0..255.
  function automatic logic [PIX_W-1:0] clamp_u8(input logic signed [KW-1:0] v);
    logic [PIX_W-1:0] r;
    if (v[KW-1])                r = '0;
    else if (|v[KW-2:PIX_W])    r = '1;
    else                        r = v[PIX_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/img_filter3x3_if.sv
// Pixel stream in/out handshake bundle for img_filter3x3.
interface img_filter3x3_if;
  import img_filter_pkg::*;

  logic             i_valid;
  logic [PIX_W-1:0] i_data;
  logic             o_ready;
  logic [1:0]       i_mode;
  logic             o_valid;
  logic [PIX_W-1:0] o_data;
  logic             i_ready;
  logic             o_eof;

  // Filter side.
  modport slave (
    input  i_valid, i_data, i_mode, i_ready,
    output o_ready, o_valid, o_data, o_eof
  );

  // Source / sink side.
  modport master (
    output i_valid, i_data, i_mode, i_ready,
    input  o_ready, o_valid, o_data, o_eof
  );
endinterface

// File: rtl/img_line_buffer.sv
// Single-port line buffer: asynchronous read of the old word, write on enable.
module img_line_buffer #(
  parameter int unsigned DEPTH = 225,
  parameter int unsigned DW    = 8,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk_i,
  input  logic          en,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata_c
);

  logic [DW-1:0] mem [DEPTH];

  // Read returns the pre-write contents of the same cycle.
  assign rdata_c = mem[addr];

  // Storage write; contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (en) mem[addr] <= wdata;
  end

endmodule

// File: rtl/img_filter3x3.sv
// Streaming 3x3 filter (pass / box / sharpen / sobel) over raster pixels.
// Build option: IMG_FILTER_SOBEL_EN enables the Sobel datapath; without it
// mode 3 behaves as pass.
module img_filter3x3
  import img_filter_pkg::*;
#(
  parameter int unsigned IMG_W = 225,
  parameter int unsigned IMG_H = 225
) (
  input  logic            clk_i,
  input  logic            rst_n,
  img_filter3x3_if.slave  bus
);

  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = $clog2(IMG_H);

  logic [XW-1:0]    x_q;
  logic [YW-1:0]    y_q;
  state_e           state_q, state_d;
  mode_e            mode_q;
  logic [PIX_W-1:0] lb1_c, lb2_c;
  logic [PIX_W-1:0] win_q [3][3];
  logic             v0_q, eof0_q, v1_q, eof1_q;
  logic [PIX_W-1:0] d1_q;
  logic             o_valid_q, o_eof_q;
  logic [PIX_W-1:0] o_data_q;
  logic             en_c, acc_c, x_last_c, y_last_c, frame_end_c;
  logic [PIX_W-1:0] kern_c;

  assign en_c        = !o_valid_q || bus.i_ready;
  assign acc_c       = bus.i_valid && en_c;
  assign x_last_c    = (x_q == XW'(IMG_W - 1));
  assign y_last_c    = (y_q == YW'(IMG_H - 1));
  assign frame_end_c = x_last_c && y_last_c;

  assign bus.o_ready = en_c;
  assign bus.o_valid = o_valid_q;
  assign bus.o_data  = o_data_q;
  assign bus.o_eof   = o_eof_q;

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else if (acc_c) begin
      if (x_last_c) begin
        x_q <= '0;
        y_q <= y_last_c ? '0 : y_q + YW'(1);
      end else begin
        x_q <= x_q + XW'(1);
      end
    end
  end

  // Frame state register.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Frame state transitions.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (acc_c) state_d = ST_FILL;
      ST_FILL: if (acc_c && (y_q == YW'(2)) && (x_q == '0)) state_d = ST_RUN;
      ST_RUN:  if (acc_c && frame_end_c) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Kernel selection is latched on the first pixel of each frame.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n)                           mode_q <= MODE_PASS;
    else if (acc_c && state_q == ST_IDLE) mode_q <= mode_e'(bus.i_mode);
  end

  // lb1 holds row y-1; lb2 takes lb1's outgoing word to hold row y-2.
  img_line_buffer #(.DEPTH(IMG_W), .DW(PIX_W)) u_lb1 (
    .clk_i   (clk_i),
    .en      (acc_c),
    .addr    (x_q),
    .wdata   (bus.i_data),
    .rdata_c (lb1_c)
  );

  img_line_buffer #(.DEPTH(IMG_W), .DW(PIX_W)) u_lb2 (
    .clk_i   (clk_i),
    .en      (acc_c),
    .addr    (x_q),
    .wdata   (lb1_c),
    .rdata_c (lb2_c)
  );

  // S0: shift the window one column left and insert the new column.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win_q[r][c] <= '0;
    end else if (acc_c) begin
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= win_q[r][2];
      end
      win_q[0][2] <= lb2_c;
      win_q[1][2] <= lb1_c;
      win_q[2][2] <= bus.i_data;
    end
  end

  // S0 control: the window is a valid interior neighbourhood.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      v0_q   <= 1'b0;
      eof0_q <= 1'b0;
    end else if (en_c) begin
      v0_q   <= acc_c && (y_q >= YW'(2)) && (x_q >= XW'(2));
      eof0_q <= acc_c && frame_end_c;
    end
  end

  logic [SUM_W-1:0]    box_sum_c;
  logic [PROD_W-1:0]   box_prod_c;
  logic signed [KW-1:0] sharp_c;

  // Box and sharpen arithmetic.
  always_comb begin
    box_sum_c = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        box_sum_c = box_sum_c + SUM_W'(win_q[r][c]);
    box_prod_c = PROD_W'(box_sum_c) * PROD_W'(BOX_MUL);
    sharp_c    = (sx(win_q[1][1]) <<< 2) + sx(win_q[1][1])
               - sx(win_q[0][1]) - sx(win_q[2][1])
               - sx(win_q[1][0]) - sx(win_q[1][2]);
  end

`ifdef IMG_FILTER_SOBEL_EN
  logic signed [KW-1:0] gx_c, gy_c, ax_c, ay_c;
  logic [PIX_W-1:0]     sobel_c;

  // Sobel gradient magnitude |gx|+|gy|, saturated.
  always_comb begin
    gx_c = sx(win_q[0][2]) + (sx(win_q[1][2]) <<< 1) + sx(win_q[2][2])
         - sx(win_q[0][0]) - (sx(win_q[1][0]) <<< 1) - sx(win_q[2][0]);
    gy_c = sx(win_q[2][0]) + (sx(win_q[2][1]) <<< 1) + sx(win_q[2][2])
         - sx(win_q[0][0]) - (sx(win_q[0][1]) <<< 1) - sx(win_q[0][2]);
    ax_c    = gx_c[KW-1] ? -gx_c : gx_c;
    ay_c    = gy_c[KW-1] ? -gy_c : gy_c;
    sobel_c = clamp_u8(ax_c + ay_c);
  end
`endif

  // Kernel result mux.
  always_comb begin
    kern_c = win_q[1][1];
    case (mode_q)
      MODE_PASS:  kern_c = win_q[1][1];
      MODE_BOX:   kern_c = PIX_W'(box_prod_c >> BOX_SHIFT);
      MODE_SHARP: kern_c = clamp_u8(sharp_c);
`ifdef IMG_FILTER_SOBEL_EN
      MODE_SOBEL: kern_c = sobel_c;
`else
      MODE_SOBEL: kern_c = win_q[1][1];
`endif
      default:    kern_c = win_q[1][1];
    endcase
  end

  // S1: registered kernel result.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      d1_q   <= '0;
      eof1_q <= 1'b0;
    end else if (en_c) begin
      v1_q   <= v0_q;
      d1_q   <= kern_c;
      eof1_q <= eof0_q;
    end
  end

  // S2: output register, held while downstream stalls.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      o_eof_q   <= 1'b0;
    end else if (en_c) begin
      o_valid_q <= v1_q;
      o_data_q  <= d1_q;
      o_eof_q   <= eof1_q;
    end
  end

endmodule

// File: tb/tb_img_filter3x3.sv
// Scoreboard bench for img_filter3x3 on a reduced frame size.
module tb_img_filter3x3;

  localparam int W  = 24;
  localparam int H  = 20;
  localparam int IX = 12;   // impulse position
  localparam int IY = 10;
  localparam int SX = 12;   // step edge column

  localparam int K_CONST = 0;
  localparam int K_RAMP  = 1;
  localparam int K_IMP   = 2;
  localparam int K_STEP  = 3;
  localparam int K_RAND  = 4;

  logic clk_i;
  logic rst_n;
  bit   stall_mode;
  bit   aborted;
  int   n_checks;
  int   n_pass;
  int   n_out;
  int   img [H][W];
  logic [8:0] exp_q [$];

  img_filter3x3_if bus ();

  img_filter3x3 #(.IMG_W(W), .IMG_H(H)) dut (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference kernel computed straight from the stored frame.
  function automatic int model_px(input int mode, input int cx, input int cy);
    int c, n, s, e, w, nw, ne, sw, se, v, gx, gy;
    c  = img[cy][cx];     n  = img[cy-1][cx];   s  = img[cy+1][cx];
    w  = img[cy][cx-1];   e  = img[cy][cx+1];
    nw = img[cy-1][cx-1]; ne = img[cy-1][cx+1];
    sw = img[cy+1][cx-1]; se = img[cy+1][cx+1];
    v = c;
    case (mode)
      1: v = ((c + n + s + e + w + nw + ne + sw + se) * 57) >> 9;
      2: begin
        v = 5 * c - n - s - e - w;
        if (v < 0) v = 0;
        if (v > 255) v = 255;
      end
`ifdef IMG_FILTER_SOBEL_EN
      3: begin
        gx = (ne + 2 * e + se) - (nw + 2 * w + sw);
        gy = (sw + 2 * s + se) - (nw + 2 * n + ne);
        v = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (v > 255) v = 255;
      end
`endif
      default: v = c;
    endcase
    return v;
  endfunction

  // Expected output whose window centre is (cx, cy).
  function automatic int exp_px(input int kind, input int mode, input int cval,
                                input int cx, input int cy);
    int v;
    case (kind)
      K_CONST: v = cval;
      K_RAMP:  v = ((cx - 1) + (cy - 1) + 2) & 255;
      K_IMP:   v = (cx == IX && cy == IY) ? 255 : 0;
`ifdef IMG_FILTER_SOBEL_EN
      K_STEP:  v = (cx == SX - 1 || cx == SX) ? 255 : 0;
`else
      K_STEP:  v = (cx < SX) ? 0 : 200;
`endif
      default: v = model_px(mode, cx, cy);
    endcase
    return v;
  endfunction

  task automatic drive_px(input int d, input int m);
    bit took;
    took = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_data  = 8'(d);
    bus.i_mode  = 2'(m);
    for (int k = 0; k < 1000 && !took; k++) begin
      @(negedge clk_i);
      took = bus.o_ready;
      @(posedge clk_i);
      #1;
    end
    if (!took) begin
      check_eq("accept_timeout", 0, 1);
      aborted = 1'b1;
    end
  endtask

  task automatic run_frame(input int kind, input int mode, input int cval,
                           input int n_px, input bit gaps);
    int idx;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        case (kind)
          K_CONST: img[y][x] = cval;
          K_RAMP:  img[y][x] = (x + y) & 255;
          K_IMP:   img[y][x] = (x == IX && y == IY) ? 255 : 0;
          K_STEP:  img[y][x] = (x < SX) ? 0 : 200;
          default: img[y][x] = int'($urandom_range(0, 255));
        endcase
    idx = 0;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        if (aborted || idx >= n_px) return;
        if (gaps && $urandom_range(0, 3) == 0) begin
          bus.i_valid = 1'b0;
          repeat ($urandom_range(1, 2)) begin
            @(posedge clk_i);
            #1;
          end
        end
        if (x >= 2 && y >= 2)
          exp_q.push_back({(x == W - 1 && y == H - 1),
                           8'(exp_px(kind, mode, cval, x - 1, y - 1))});
        // Mode is only meaningful on the first pixel; scramble it afterwards.
        drive_px(img[y][x], (idx == 0) ? mode : int'($urandom_range(0, 3)));
        idx++;
      end
    end
  endtask

  task automatic drain();
    bus.i_valid = 1'b0;
    stall_mode  = 1'b0;
    for (int k = 0; k < 300 && exp_q.size() != 0; k++) begin
      @(posedge clk_i);
      #1;
    end
    check_eq("drain_left", exp_q.size(), 0);
    repeat (5) @(posedge clk_i);
    #1;
  endtask

  // Downstream ready: constant high, or toggling every cycle when stalling.
  initial begin
    bus.i_ready = 1'b1;
    forever begin
      @(posedge clk_i);
      #1;
      bus.i_ready = stall_mode ? ~bus.i_ready : 1'b1;
    end
  end

  // Output monitor: scoreboard pop on transfer, stability check on stall.
  initial begin
    bit         held;
    logic [7:0] held_data;
    logic       held_eof;
    logic [8:0] e;
    held = 1'b0;
    held_data = '0;
    held_eof = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!rst_n) begin
        held = 1'b0;
      end else begin
        if (held) begin
          check_eq("hold_valid", int'(bus.o_valid), 1);
          check_eq("hold_data", int'(bus.o_data), int'(held_data));
          check_eq("hold_eof", int'(bus.o_eof), int'(held_eof));
        end
        held      = bus.o_valid && !bus.i_ready;
        held_data = bus.o_data;
        held_eof  = bus.o_eof;
        if (bus.o_valid && bus.i_ready) begin
          if (exp_q.size() == 0) begin
            check_eq("extra_output", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check_eq($sformatf("data#%0d", n_out), int'(bus.o_data), int'(e[7:0]));
            check_eq($sformatf("eof#%0d", n_out), int'(bus.o_eof), int'(e[8]));
          end
          n_out++;
        end
      end
    end
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    n_out    = 0;
    aborted  = 1'b0;
    stall_mode = 1'b0;
    rst_n = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    bus.i_mode  = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_eq("rst_o_valid", int'(bus.o_valid), 0);
    check_eq("rst_o_data", int'(bus.o_data), 0);
    check_eq("rst_o_eof", int'(bus.o_eof), 0);
    @(posedge clk_i);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    check_eq("idle_o_valid", int'(bus.o_valid), 0);
    check_eq("idle_o_ready", int'(bus.o_ready), 1);

    // Back-to-back directed frames, no stalls.
    run_frame(K_CONST, 1, 100, W * H, 1'b0);
    run_frame(K_RAMP,  0, 0,   W * H, 1'b0);
    run_frame(K_IMP,   2, 0,   W * H, 1'b0);
    run_frame(K_STEP,  3, 0,   W * H, 1'b0);
    drain();

    // Random frames under downstream toggling and input gaps.
    stall_mode = 1'b1;
    run_frame(K_RAND, 2, 0, W * H, 1'b1);
    run_frame(K_RAND, 1, 0, W * H, 1'b1);
    run_frame(K_RAND, 3, 0, W * H, 1'b1);
    run_frame(K_RAND, 0, 0, W * H, 1'b1);
    drain();

    // Reset in mid-frame, then a fresh frame from (0,0).
    run_frame(K_CONST, 1, 77, 100, 1'b0);
    bus.i_valid = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk_i);
    check_eq("midrst_o_valid", int'(bus.o_valid), 0);
    check_eq("midrst_o_data", int'(bus.o_data), 0);
    @(posedge clk_i);
    #1;
    rst_n = 1'b1;
    run_frame(K_CONST, 1, 50, W * H, 1'b0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
